decode_stage_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle decode stage.
- Holds the 8-entry register file with optional write-to-read bypass, operand selection and immediate extension generalised to DATA_W, and a load-use interlock.
- Ends in an ID/EX pipeline register with valid/ready handshaking and flush.
- Sits between the fetch/IF-ID register and the execute stage.

---
 rtl/decode_stage_pipe_if.sv | 49 ++++
 rtl/decode_stage_pipe.sv | 130 +++++++++++++
 tb/tb_decode_stage_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipe_if.sv
// Decode stage bus: upstream instruction with valid/ready, register writeback
// port, and the ID/EX register outputs toward execute.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [1:0]        reg_dst;
    logic              zero_ext;
    logic              reg_wrt;
    logic              is_load;
    logic              rs_used;
    logic              rt_used;
    logic              flush;
    logic              wb_en;
    logic [2:0]        wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm5;
    logic [DATA_W-1:0] out_imm8;
    logic [DATA_W-1:0] out_simm8;
    logic [DATA_W-1:0] out_simm11;
    logic [DATA_W-1:0] out_pc;
    logic [2:0]        out_rd;
    logic              out_reg_wrt;
    logic              out_is_load;
    logic              err;

    modport master (
        output in_valid, instr, pc, reg_dst, zero_ext, reg_wrt, is_load,
               rs_used, rt_used, flush, wb_en, wb_sel, wb_data, out_ready,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm5,
               out_imm8, out_simm8, out_simm11, out_pc, out_rd, out_reg_wrt,
               out_is_load, err
    );

    modport slave (
        input  in_valid, instr, pc, reg_dst, zero_ext, reg_wrt, is_load,
               rs_used, rt_used, flush, wb_en, wb_sel, wb_data, out_ready,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm5,
               out_imm8, out_simm8, out_simm11, out_pc, out_rd, out_reg_wrt,
               out_is_load, err
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: 8-entry register file, operand/immediate decode,
// load-use interlock and an ID/EX register with valid/ready and flush.
module decode_stage_pipe #(
    parameter int                DATA_W     = 16,
    parameter bit                BYPASS     = 1'b1,
    parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
    input logic                clk,
    input logic                rst,
    decode_stage_pipe_if.slave bus_if
);
    logic [DATA_W-1:0]        rf_q [8];

    logic [2:0]               rs, rt, rd;
    logic [DATA_W-1:0]        rs_val, rt_val;
    logic signed [DATA_W-1:0] imm5_sx, simm8, simm11;
    logic [DATA_W-1:0]        imm5, imm8;
    logic                     hazard, advance, in_ready, capture;

    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        rs_data_q, rt_data_q, pc_q;
    logic [DATA_W-1:0]        imm5_q, imm8_q, simm8_q, simm11_q;
    logic [2:0]               rd_q;
    logic                     reg_wrt_q, is_load_q;

    logic                     err_q, err_d;
    logic                     stall_q, stall_d;
    logic [15:0]              stall_instr_q;
    logic [DATA_W-1:0]        stall_pc_q;

    assign rs     = bus_if.instr[10:8];
    assign rt     = bus_if.instr[7:5];
    assign rs_val = (BYPASS && bus_if.wb_en && (bus_if.wb_sel == rs)) ? bus_if.wb_data : rf_q[rs];
    assign rt_val = (BYPASS && bus_if.wb_en && (bus_if.wb_sel == rt)) ? bus_if.wb_data : rf_q[rt];

    always_comb begin
        rd = 3'd7;
        case (bus_if.reg_dst)
            2'b00:   rd = bus_if.instr[7:5];
            2'b01:   rd = bus_if.instr[10:8];
            2'b10:   rd = bus_if.instr[4:2];
            default: rd = 3'd7;
        endcase
    end

    assign imm5_sx = {{(DATA_W-5){bus_if.instr[4]}}, bus_if.instr[4:0]};
    assign simm8   = {{(DATA_W-8){bus_if.instr[7]}}, bus_if.instr[7:0]};
    assign simm11  = {{(DATA_W-11){bus_if.instr[10]}}, bus_if.instr[10:0]};
    assign imm5    = bus_if.zero_ext ? {{(DATA_W-5){1'b0}}, bus_if.instr[4:0]} : imm5_sx;
    assign imm8    = bus_if.zero_ext ? {{(DATA_W-8){1'b0}}, bus_if.instr[7:0]} : simm8;

    assign hazard  = bus_if.in_valid & out_valid_q & is_load_q & reg_wrt_q &
                     ((bus_if.rs_used & (rd_q == rs)) | (bus_if.rt_used & (rd_q == rt)));
    assign advance  = ~out_valid_q | bus_if.out_ready;
    assign in_ready = (advance & ~hazard) | bus_if.flush;
    assign capture  = bus_if.in_valid & in_ready & ~bus_if.flush;

    // A hazard forces in_ready low, so capture=0 and advance inserts the bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        if (bus_if.flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = capture;
        end
    end

    assign stall_d = bus_if.in_valid & ~in_ready & ~bus_if.flush;
    assign err_d   = err_q | (stall_q & (~bus_if.in_valid |
                                         (bus_if.instr != stall_instr_q) |
                                         (bus_if.pc != stall_pc_q)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= RF_RST_VAL;
            end
            out_valid_q   <= 1'b0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm5_q        <= '0;
            imm8_q        <= '0;
            simm8_q       <= '0;
            simm11_q      <= '0;
            pc_q          <= '0;
            rd_q          <= '0;
            reg_wrt_q     <= 1'b0;
            is_load_q     <= 1'b0;
            err_q         <= 1'b0;
            stall_q       <= 1'b0;
            stall_instr_q <= '0;
            stall_pc_q    <= '0;
        end else begin
            if (bus_if.wb_en) begin
                rf_q[bus_if.wb_sel] <= bus_if.wb_data;
            end
            out_valid_q   <= out_valid_d;
            err_q         <= err_d;
            stall_q       <= stall_d;
            stall_instr_q <= bus_if.instr;
            stall_pc_q    <= bus_if.pc;
            if (capture) begin
                rs_data_q <= rs_val;
                rt_data_q <= rt_val;
                imm5_q    <= imm5;
                imm8_q    <= imm8;
                simm8_q   <= simm8;
                simm11_q  <= simm11;
                pc_q      <= bus_if.pc;
                rd_q      <= rd;
                reg_wrt_q <= bus_if.reg_wrt;
                is_load_q <= bus_if.is_load;
            end
        end
    end

    assign bus_if.in_ready    = in_ready;
    assign bus_if.out_valid   = out_valid_q;
    assign bus_if.out_rs_data = rs_data_q;
    assign bus_if.out_rt_data = rt_data_q;
    assign bus_if.out_imm5    = imm5_q;
    assign bus_if.out_imm8    = imm8_q;
    assign bus_if.out_simm8   = simm8_q;
    assign bus_if.out_simm11  = simm11_q;
    assign bus_if.out_pc      = pc_q;
    assign bus_if.out_rd      = rd_q;
    assign bus_if.out_reg_wrt = reg_wrt_q;
    assign bus_if.out_is_load = is_load_q;
    assign bus_if.err         = err_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: directed scenarios then random traffic
// checked against a cycle-level behavioural model of the decode stage.
module tb_decode_stage_pipe;
    localparam int            DW   = 16;
    localparam bit            BYP  = 1'b1;
    localparam logic [DW-1:0] RSTV = 16'h5A5A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(DW)) bus ();

    decode_stage_pipe #(.DATA_W(DW), .BYPASS(BYP), .RF_RST_VAL(RSTV)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    typedef struct packed {
        logic          rst;
        logic          in_valid;
        logic [15:0]   instr;
        logic [DW-1:0] pc;
        logic [1:0]    reg_dst;
        logic          zero_ext;
        logic          reg_wrt;
        logic          is_load;
        logic          rs_used;
        logic          rt_used;
        logic          flush;
        logic          wb_en;
        logic [2:0]    wb_sel;
        logic [DW-1:0] wb_data;
        logic          out_ready;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm5;
        logic [DW-1:0] imm8;
        logic [DW-1:0] simm8;
        logic [DW-1:0] simm11;
        logic [DW-1:0] pc;
        logic [2:0]    rd;
        logic          reg_wrt;
        logic          is_load;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Reference model state: architectural registers plus what sits in ID/EX.
    logic [DW-1:0] mrf [8];
    logic          mvalid = 1'b0;
    exp_t          held   = '0;
    logic          err_m  = 1'b0;
    logic          pstall = 1'b0;
    logic [15:0]   pinstr = '0;
    logic [DW-1:0] ppc    = '0;
    stim_t         last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sext(input int v, input int bits);
        int s;
        s = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mread(input stim_t s, input logic [2:0] r);
        if (BYP && s.wb_en && (s.wb_sel == r)) return s.wb_data;
        return mrf[r];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s           = '0;
        s.rst       = 1'b1;
        s.out_ready = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst           = s.rst;
        bus.in_valid  = s.in_valid;
        bus.instr     = s.instr;
        bus.pc        = s.pc;
        bus.reg_dst   = s.reg_dst;
        bus.zero_ext  = s.zero_ext;
        bus.reg_wrt   = s.reg_wrt;
        bus.is_load   = s.is_load;
        bus.rs_used   = s.rs_used;
        bus.rt_used   = s.rt_used;
        bus.flush     = s.flush;
        bus.wb_en     = s.wb_en;
        bus.wb_sel    = s.wb_sel;
        bus.wb_data   = s.wb_data;
        bus.out_ready = s.out_ready;
    endtask

    // Check the handshake outputs against the model, then advance the model one edge.
    task automatic model_eval(input stim_t s);
        logic [2:0] rs, rt;
        logic       adv, haz, exp_rdy, cap;
        exp_t       e;
        int         i5, i8, i11;
        rs      = s.instr[10:8];
        rt      = s.instr[7:5];
        haz     = s.in_valid && mvalid && held.is_load && held.reg_wrt &&
                  ((s.rs_used && (held.rd == rs)) || (s.rt_used && (held.rd == rt)));
        adv     = !mvalid || s.out_ready;
        exp_rdy = (adv && !haz) || s.flush;
        cap     = s.in_valid && exp_rdy && !s.flush;
        chk("out_valid", bus.out_valid, mvalid);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("err", bus.err, err_m);

        i5  = int'(s.instr[4:0]);
        i8  = int'(s.instr[7:0]);
        i11 = int'(s.instr[10:0]);
        e.rs_data = mread(s, rs);
        e.rt_data = mread(s, rt);
        e.imm5    = s.zero_ext ? DW'(i5) : sext(i5, 5);
        e.imm8    = s.zero_ext ? DW'(i8) : sext(i8, 8);
        e.simm8   = sext(i8, 8);
        e.simm11  = sext(i11, 11);
        e.pc      = s.pc;
        case (s.reg_dst)
            2'b00:   e.rd = s.instr[7:5];
            2'b01:   e.rd = s.instr[10:8];
            2'b10:   e.rd = s.instr[4:2];
            default: e.rd = 3'd7;
        endcase
        e.reg_wrt = s.reg_wrt;
        e.is_load = s.is_load;

        if (!s.rst) begin
            for (int i = 0; i < 8; i++) mrf[i] = RSTV;
            mvalid = 1'b0;
            held   = '0;
            err_m  = 1'b0;
            pstall = 1'b0;
            sb.delete();
        end else begin
            if (pstall && (!s.in_valid || (s.instr != pinstr) || (s.pc != ppc))) err_m = 1'b1;
            pstall = s.in_valid && !exp_rdy && !s.flush;
            pinstr = s.instr;
            ppc    = s.pc;
            if (s.flush) begin
                mvalid = 1'b0;
                sb.delete();
            end else if (adv) begin
                mvalid = cap;
                if (cap) begin
                    held = e;
                    sb.push_back(e);
                end
            end
            if (s.wb_en) mrf[s.wb_sel] = s.wb_data;
        end
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        apply(s);
        last = s;
        @(negedge clk);
        model_eval(s);
    endtask

    // Monitor: every instruction handed to execute must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && !bus.flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got out_valid=1 pc=0x%0h expected no transfer at %0t", bus.out_pc, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("rs_data", bus.out_rs_data, mon_e.rs_data);
                chk("rt_data", bus.out_rt_data, mon_e.rt_data);
                chk("imm5", bus.out_imm5, mon_e.imm5);
                chk("imm8", bus.out_imm8, mon_e.imm8);
                chk("simm8", bus.out_simm8, mon_e.simm8);
                chk("simm11", bus.out_simm11, mon_e.simm11);
                chk("pc", bus.out_pc, mon_e.pc);
                chk("rd", bus.out_rd, mon_e.rd);
                chk("reg_wrt", bus.out_reg_wrt, mon_e.reg_wrt);
                chk("is_load", bus.out_is_load, mon_e.is_load);
            end
        end
    end

    initial begin
        stim_t s, t, u, r;
        for (int i = 0; i < 8; i++) mrf[i] = RSTV;
        apply(idle());
        rst = 1'b0;

        s = idle(); s.rst = 1'b0;
        step(s);
        step(s);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_rs", bus.out_rs_data, 0);
        chk("rst_out_imm5", bus.out_imm5, 0);
        chk("rst_out_rd", bus.out_rd, 0);

        // Basic read after writeback.
        s = idle(); s.wb_en = 1'b1; s.wb_sel = 3'd3; s.wb_data = 16'h1234;
        step(s);
        s = idle(); s.in_valid = 1'b1; s.instr = 16'h4360; s.pc = 16'h0100;
        s.rs_used = 1'b1; s.rt_used = 1'b1; s.reg_wrt = 1'b1;
        step(s);
        step(idle());
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_rs", bus.out_rs_data, 16'h1234);
        chk("basic_rt", bus.out_rt_data, 16'h1234);
        chk("basic_rd", bus.out_rd, 3);

        // Immediate extension.
        s = idle(); s.in_valid = 1'b1; s.instr = 16'h0095; s.pc = 16'h0110;
        step(s);
        step(idle());
        chk("imm5_sx", bus.out_imm5, 16'hFFF5);
        chk("imm8_sx", bus.out_imm8, 16'hFF95);
        chk("simm8", bus.out_simm8, 16'hFF95);
        s.zero_ext = 1'b1;
        step(s);
        step(idle());
        chk("imm5_zx", bus.out_imm5, 16'h0015);
        chk("imm8_zx", bus.out_imm8, 16'h0095);
        s = idle(); s.in_valid = 1'b1; s.instr = 16'h04A0;
        step(s);
        step(idle());
        chk("simm11", bus.out_simm11, 16'hFCA0);

        // Same-cycle writeback bypass, then a plain read of the stored value.
        s = idle(); s.in_valid = 1'b1; s.instr = 16'h0200; s.rs_used = 1'b1;
        s.wb_en = 1'b1; s.wb_sel = 3'd2; s.wb_data = 16'hBEEF;
        step(s);
        step(idle());
        chk("bypass_rs", bus.out_rs_data, BYP ? 16'hBEEF : RSTV);
        s.wb_en = 1'b0;
        step(s);
        step(idle());
        chk("r2_after_wb", bus.out_rs_data, 16'hBEEF);

        // Load-use interlock: one bubble, then the dependent instruction.
        t = idle(); t.in_valid = 1'b1; t.instr = 16'h0010; t.reg_dst = 2'b10;
        t.is_load = 1'b1; t.reg_wrt = 1'b1; t.pc = 16'h0120;
        u = idle(); u.in_valid = 1'b1; u.instr = 16'h0400; u.rs_used = 1'b1; u.pc = 16'h0124;
        step(t);
        step(u);
        chk("lu_stall", bus.in_ready, 0);
        step(u);
        chk("lu_bubble", bus.out_valid, 0);
        chk("lu_ready", bus.in_ready, 1);
        step(idle());
        chk("lu_dep_valid", bus.out_valid, 1);
        chk("lu_dep_pc", bus.out_pc, 16'h0124);
        step(t);
        u.rs_used = 1'b0;
        step(u);
        chk("lu_nostall", bus.in_ready, 1);
        step(idle());

        // Backpressure then flush.
        s = idle(); s.in_valid = 1'b1; s.instr = 16'h1234; s.pc = 16'h0200; s.out_ready = 1'b0;
        step(s);
        t = s; t.instr = 16'h5678; t.pc = 16'h0204;
        for (int k = 0; k < 3; k++) begin
            step(t);
            chk("bp_ready", bus.in_ready, 0);
            chk("bp_pc_stable", bus.out_pc, 16'h0200);
        end
        t.flush = 1'b1;
        step(t);
        chk("flush_ready", bus.in_ready, 1);
        step(idle());
        chk("flush_valid", bus.out_valid, 0);

        // Protocol error: instruction changes while stalled; sticky until reset.
        s.pc = 16'h0300;
        step(s);
        t = s; t.pc = 16'h0304;
        step(t);
        t.instr = 16'h7777;
        step(t);
        step(t);
        chk("err_set", bus.err, 1);
        step(t);
        chk("err_sticky", bus.err, 1);
        r = idle(); r.rst = 1'b0;
        step(r);
        step(idle());
        chk("err_rst", bus.err, 0);
        chk("valid_rst", bus.out_valid, 0);

        // Reset in the middle of a stall drops the held request without an error.
        s.pc = 16'h0400;
        step(s);
        t = s; t.pc = 16'h0404;
        step(t);
        t.rst = 1'b0;
        step(t);
        step(idle());
        step(idle());
        chk("rst_midstall_err", bus.err, 0);

        // Randomized traffic; upstream holds its request while stalled.
        for (int k = 0; k < 3000; k++) begin
            if (pstall) begin
                r = last;
            end else begin
                r          = idle();
                r.in_valid = ($urandom_range(0, 9) < 7);
                r.instr    = 16'($urandom);
                r.pc       = DW'($urandom);
                r.reg_dst  = 2'($urandom);
                r.zero_ext = 1'($urandom);
                r.reg_wrt  = ($urandom_range(0, 9) < 6);
                r.is_load  = ($urandom_range(0, 9) < 3);
                r.rs_used  = 1'($urandom);
                r.rt_used  = 1'($urandom);
            end
            r.rst       = ($urandom_range(0, 199) != 0);
            r.flush     = ($urandom_range(0, 24) == 0);
            r.wb_en     = 1'($urandom);
            r.wb_sel    = 3'($urandom);
            r.wb_data   = DW'($urandom);
            r.out_ready = ($urandom_range(0, 9) < 7);
            step(r);
        end
        for (int k = 0; k < 4; k++) step(idle());
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
